// File: rtl/alu_serial_tx_if.sv
// Word-in / bit-out bundle between a byte-wide source, the serialiser and the ALU x input.
// Handshake: a word transfers on a rising edge where valid && ready; valid may rise at any time and data_in is only sampled on that edge.
interface alu_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             sdata;
    logic             sframe;
    logic             done;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output data_in, valid,
        input  ready, sdata, sframe, done, busy, dbg_state
    );

    modport slave (
        input  data_in, valid,
        output ready, sdata, sframe, done, busy, dbg_state
    );
endinterface

// File: rtl/alu_serial_tx.sv
// Parallel-in serial-out transmitter: one word per handshake, one bit per clock,
// optional even-parity bit and a fixed idle gap, every output registered.
module alu_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY    = 0,
    parameter int GAP       = 1
) (
    input  logic           clock,
    input  logic           reset,
    alu_serial_tx_if.slave bus
);
    localparam int         CW    = $clog2(WIDTH + 1);
    localparam logic [3:0] GAP_L = 4'(GAP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [3:0]       r_gap, w_gap;
    logic             r_par, w_par;
    logic             r_ready, w_ready;
    logic             r_sdata, w_sdata;
    logic             r_sframe, w_sframe;
    logic             r_done, w_done;
    logic             r_busy, w_busy;
    logic             w_handshake;
    logic             w_end_frame;

    assign w_handshake = bus.valid & r_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_gap    <= '0;
            r_par    <= 1'b0;
            r_ready  <= 1'b0;
            r_sdata  <= 1'b0;
            r_sframe <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shift  <= w_shift;
            r_cnt    <= w_cnt;
            r_gap    <= w_gap;
            r_par    <= w_par;
            r_ready  <= w_ready;
            r_sdata  <= w_sdata;
            r_sframe <= w_sframe;
            r_done   <= w_done;
            r_busy   <= w_busy;
        end
    end

    // Outputs are computed for the state being entered, so each register holds
    // exactly what the bus shows during the following cycle.
    always_comb begin
        w_state     = r_state;
        w_shift     = r_shift;
        w_cnt       = r_cnt;
        w_gap       = r_gap;
        w_par       = r_par;
        w_ready     = 1'b0;
        w_sdata     = 1'b0;
        w_sframe    = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        w_end_frame = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
                if (w_handshake) begin
                    w_state  = S_SHIFT;
                    w_ready  = 1'b0;
                    w_busy   = 1'b1;
                    w_sframe = 1'b1;
                    w_cnt    = CW'(WIDTH);
                    w_par    = 1'b0;
                    if (MSB_FIRST != 0) begin
                        w_sdata = bus.data_in[WIDTH-1];
                        w_shift = bus.data_in << 1;
                    end else begin
                        w_sdata = bus.data_in[0];
                        w_shift = bus.data_in >> 1;
                    end
                end
            end
            S_SHIFT: begin
                // r_sdata is the bit on the wire this cycle; fold it into parity.
                w_par = r_par ^ r_sdata;
                if (r_cnt == CW'(1)) begin
                    if (PARITY != 0) begin
                        w_state  = S_PAR;
                        w_sframe = 1'b1;
                        w_sdata  = r_par ^ r_sdata;
                    end else begin
                        w_end_frame = 1'b1;
                    end
                end else begin
                    w_cnt    = r_cnt - CW'(1);
                    w_sframe = 1'b1;
                    if (MSB_FIRST != 0) begin
                        w_sdata = r_shift[WIDTH-1];
                        w_shift = r_shift << 1;
                    end else begin
                        w_sdata = r_shift[0];
                        w_shift = r_shift >> 1;
                    end
                end
            end
            S_PAR: begin
                w_end_frame = 1'b1;
            end
            S_GAP: begin
                if (r_gap == 4'd1) begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                end else begin
                    w_gap = r_gap - 4'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // done marks the first cycle after the last frame bit, wherever that lands.
        if (w_end_frame) begin
            w_done = 1'b1;
            if (GAP > 0) begin
                w_state = S_GAP;
                w_gap   = GAP_L;
            end else begin
                w_state = S_IDLE;
                w_ready = 1'b1;
                w_busy  = 1'b0;
            end
        end
    end

    assign bus.ready     = r_ready;
    assign bus.sdata     = r_sdata;
    assign bus.sframe    = r_sframe;
    assign bus.done      = r_done;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_alu_serial_tx.sv
// Bench for alu_serial_tx: two configurations (defaults, and LSB-first/parity/no-gap)
// checked cycle by cycle against a frame model built from the word's bits.
module tb_alu_serial_tx;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [0:0] exp_q[$];

    alu_serial_tx_if #(.WIDTH(8)) bus0();
    alu_serial_tx_if #(.WIDTH(8)) bus1();

    alu_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY(0), .GAP(1)) u_dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus0.slave)
    );

    alu_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY(1), .GAP(0)) u_dut1 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus1.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // configuration of each instance as the model sees it
    function automatic int cfg_gap(input int sel);
        return (sel == 0) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin
            bus0.valid   = v;
            bus0.data_in = d;
        end else begin
            bus1.valid   = v;
            bus1.data_in = d;
        end
    endtask

    task automatic get(input int sel, output logic rdy, output logic sd, output logic sf,
                       output logic dn, output logic bz);
        if (sel == 0) begin
            rdy = bus0.ready; sd = bus0.sdata; sf = bus0.sframe; dn = bus0.done; bz = bus0.busy;
        end else begin
            rdy = bus1.ready; sd = bus1.sdata; sf = bus1.sframe; dn = bus1.done; bz = bus1.busy;
        end
    endtask

    task automatic check_quiet(input string tag, input int sel);
        logic r, sd, sf, dn, bz;
        get(sel, r, sd, sf, dn, bz);
        check({tag, "_ready"}, r, 0);
        check({tag, "_sdata"}, sd, 0);
        check({tag, "_sframe"}, sf, 0);
        check({tag, "_done"}, dn, 0);
        check({tag, "_busy"}, bz, 0);
    endtask

    task automatic wait_ready(input int sel);
        logic r, sd, sf, dn, bz;
        int n;
        n = 0;
        get(sel, r, sd, sf, dn, bz);
        while (!r && n < 50) begin
            @(negedge clk);
            n++;
            get(sel, r, sd, sf, dn, bz);
        end
        check("ready_wait", r, 1);
    endtask

    // reference model: the frame is the word's bits in wire order, then the parity bit
    task automatic build_frame(input int sel, input logic [7:0] w);
        logic [7:0] word;
        int idx;
        word = w;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            idx = (sel == 0) ? (7 - i) : i;
            exp_q.push_back(word[idx]);
        end
        if (sel == 1) exp_q.push_back(1'($countones(word) % 2));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle
    // cycle that follows the frame and its gap.
    task automatic run_frame(input int sel, input logic [7:0] w, input bit hold_valid);
        logic r, sd, sf, dn, bz;
        int n, gap;
        gap = cfg_gap(sel);
        wait_ready(sel);
        drive(sel, 1'b1, w);
        build_frame(sel, w);
        n = exp_q.size();
        @(negedge clk);
        if (!hold_valid) drive(sel, 1'b0, 8'($urandom));
        for (int i = 0; i < n; i++) begin
            get(sel, r, sd, sf, dn, bz);
            check("bit_sframe", sf, 1);
            check("bit_sdata", sd, exp_q.pop_front());
            check("bit_ready", r, 0);
            check("bit_busy", bz, 1);
            check("bit_done", dn, 0);
            @(negedge clk);
            if (!hold_valid) drive(sel, 1'b0, 8'($urandom));
        end
        for (int g = 0; g < gap; g++) begin
            get(sel, r, sd, sf, dn, bz);
            check("gap_sframe", sf, 0);
            check("gap_sdata", sd, 0);
            check("gap_ready", r, 0);
            check("gap_busy", bz, 1);
            check("gap_done", dn, (g == 0) ? 1 : 0);
            @(negedge clk);
            if (!hold_valid) drive(sel, 1'b0, 8'($urandom));
        end
        get(sel, r, sd, sf, dn, bz);
        check("idle_ready", r, 1);
        check("idle_busy", bz, 0);
        check("idle_sframe", sf, 0);
        check("idle_sdata", sd, 0);
        check("idle_done", dn, (gap == 0) ? 1 : 0);
    endtask

    initial begin
        logic r, sd, sf, dn, bz;
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);

        // reset holds every output low
        repeat (3) begin
            @(negedge clk);
            check_quiet("rst0", 0);
            check_quiet("rst1", 1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            get(s, r, sd, sf, dn, bz);
            check("post_rst_ready", r, 1);
            check("post_rst_busy", bz, 0);
            check("post_rst_sframe", sf, 0);
        end

        // directed words
        run_frame(0, 8'hA5, 1'b0);
        run_frame(1, 8'h07, 1'b0);
        run_frame(1, 8'hA5, 1'b0);

        // back-to-back with valid held high
        run_frame(0, 8'h3C, 1'b1);
        run_frame(0, 8'hFF, 1'b0);

        // reset in the middle of the 4th bit of 0xF0
        wait_ready(0);
        drive(0, 1'b1, 8'hF0);
        build_frame(0, 8'hF0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            get(0, r, sd, sf, dn, bz);
            check("abort_sframe", sf, 1);
            check("abort_sdata", sd, exp_q.pop_front());
            if (i < 3) @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        check_quiet("abort_async", 0);
        repeat (2) begin
            @(negedge clk);
            check_quiet("abort_hold", 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        get(0, r, sd, sf, dn, bz);
        check("abort_ready", r, 1);
        check("abort_done", dn, 0);
        run_frame(0, 8'h81, 1'b0);

        // randomized words on both configurations
        for (int k = 0; k < 6; k++) begin
            run_frame(0, 8'($urandom_range(0, 255)), 1'b0);
            run_frame(1, 8'($urandom_range(0, 255)), 1'b0);
        end
        run_frame(1, 8'($urandom_range(0, 255)), 1'b1);
        run_frame(1, 8'($urandom_range(0, 255)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
